// File: rtl/opcode_executor.sv
// ---------------------------------------------------------------------------
// opcode_executor
//
// Executes one operation on two WIDTH-bit operands per start request and
// presents a registered 2*WIDTH-bit result.
//   - Single-cycle ops (0,1,3,4,7-15, divide-by-zero): one CALC cycle.
//   - Multiply (5) shift-add and divide (6) restoring: WIDTH CALC cycles.
//   - Count mode (2): free-running counter stepping every TICK_DIV clocks,
//     left only by a new start pulse.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   start   in   execute request, honoured in IDLE (and to exit count mode)
//   opcode  in   [3:0] operation select
//   a, b    in   [WIDTH-1:0] operands
//   busy    out  state is not IDLE
//   done    out  one-cycle pulse while in DONE (result just updated)
//   result  out  [2*WIDTH-1:0] registered result
//   error   out  divide-by-zero flag, valid with done
//
// Handshake: start is a level sampled on the rising edge; in IDLE a sampled
// start latches opcode/a/b and moves to CALC on that same edge. Inputs are
// not looked at again until the operation ends, so they may change freely.
// ---------------------------------------------------------------------------
module opcode_executor #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 error
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);

    localparam logic [3:0] OP_COUNT = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Shared iteration registers:
    //   multiply: acc = partial product, sh = shifted multiplicand, mq = multiplier
    //   divide:   acc = partial remainder, mq = dividend shifting into quotient
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    sh_q, sh_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [RW-1:0]    result_q, result_d;
    logic             error_q, error_d;

    // Single-cycle datapath
    logic [RW-1:0]    alu_res;
    logic [WIDTH:0]   sub_res;

    // Multiply step
    logic [RW-1:0]    mul_acc;

    // Divide step
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_quo;

    always_comb begin
        sub_res = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        case (op_q)
            4'd0:    alu_res = {b_q, a_q};
            4'd1:    alu_res = '1;
            4'd3:    alu_res = RW'({1'b0, a_q} + {1'b0, b_q});
            // WIDTH+1-bit difference, sign bit replicated upward
            4'd4:    alu_res = {{(RW - WIDTH - 1){sub_res[WIDTH]}}, sub_res};
            4'd7:    alu_res = {{WIDTH{1'b0}}, a_q} << b_q[2:0];
            4'd8:    alu_res = {{WIDTH{1'b0}}, a_q >> b_q[2:0]};
            4'd9:    alu_res = {{WIDTH{1'b0}}, a_q & b_q};
            4'd10:   alu_res = {{WIDTH{1'b0}}, a_q | b_q};
            4'd11:   alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            4'd12:   alu_res = {{WIDTH{1'b0}}, ~a_q};
            4'd13:   alu_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
            4'd14:   alu_res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
            4'd15:   alu_res = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        mul_acc = acc_q + (mq_q[0] ? sh_q : '0);
    end

    // Restoring division step: bring the next dividend bit into the
    // remainder, subtract the divisor if it fits, record the quotient bit.
    always_comb begin
        div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? div_diff : div_shift;
        div_quo   = {mq_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        mq_d     = mq_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    sh_d    = {{WIDTH{1'b0}}, a};
                    mq_d    = (opcode == OP_DIV) ? a : b;
                    cnt_d   = '0;
                    pre_d   = '0;
                    if (opcode == OP_COUNT) begin
                        result_d = '0;
                        error_d  = 1'b0;
                    end
                    state_d = CALC;
                end
            end

            CALC: begin
                case (op_q)
                    OP_COUNT: begin
                        if (start) begin
                            state_d = IDLE;
                        end else if (pre_q == PRE_MAX) begin
                            pre_d    = '0;
                            result_d = result_q + RW'(1);
                        end else begin
                            pre_d = pre_q + PW'(1);
                        end
                    end

                    OP_MUL: begin
                        acc_d = mul_acc;
                        sh_d  = sh_q << 1;
                        mq_d  = mq_q >> 1;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            result_d = mul_acc;
                            error_d  = 1'b0;
                            state_d  = DONE;
                        end
                    end

                    OP_DIV: begin
                        if (b_q == '0) begin
                            result_d = '1;
                            error_d  = 1'b1;
                            state_d  = DONE;
                        end else begin
                            acc_d = RW'(div_rem);
                            mq_d  = div_quo;
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_q == LAST_ITER) begin
                                result_d = {div_rem[WIDTH-1:0], div_quo};
                                error_d  = 1'b0;
                                state_d  = DONE;
                            end
                        end
                    end

                    default: begin
                        result_d = alu_res;
                        error_d  = 1'b0;
                        state_d  = DONE;
                    end
                endcase
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            mq_q     <= mq_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: doc/opcode_executor.md
OPCODE_EXECUTOR -- requirements
Module: opcode_executor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits; result width is 2*WIDTH.
REQ-002 The block SHALL have parameter TICK_DIV, default 50_000_000, meaning the clk cycles per count step in opcode 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to execute, sampled on the clk rising edge.
REQ-007 The block SHALL have port opcode, input, 4 bits: the operation select produced by the opcode decoder.
REQ-008 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-009 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when result is updated.
REQ-012 The block SHALL have port result, output, 2*WIDTH bits: the registered operation result.
REQ-013 The block SHALL have port error, output, 1 bit: divide-by-zero flag, valid with done.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 In IDLE, on start=1, the block SHALL latch opcode, a and b, and go to CALC on that same edge.
REQ-016 For single-cycle ops (0,1,3,4,7-15 and divide-by-zero), CALC SHALL write result and error, then go to DONE; done SHALL be 1 during DONE (2 cycles after the start edge), then IDLE.
REQ-017 Opcode 5 (multiply) SHALL use shift-add, WIDTH iterations in CALC; result = a*b unsigned; done SHALL be 1 exactly WIDTH+1 cycles after the start edge.
REQ-018 Opcode 6 (divide) SHALL use restoring division, WIDTH iterations; result = {remainder, quotient}; latency SHALL be the same as multiply.
REQ-019 For opcode 6 with b=0, the block SHALL set result = all ones and error=1, with single-cycle latency.
REQ-020 For every opcode other than 6, error SHALL be 0.
REQ-021 Opcode 0 SHALL give result = {b,a}.
REQ-022 Opcode 1 (lamp test) SHALL give result = all ones.
REQ-023 Opcode 3 SHALL give result = a+b zero-extended, carry in bit WIDTH.
REQ-024 Opcode 4 SHALL give result = (a-b) as a WIDTH+1-bit two's-complement value, sign-extended to 2*WIDTH.
REQ-025 Opcode 7 SHALL give result = zero-extended a shifted left by b[2:0]; opcode 8 SHALL give zero-extended a shifted logically right by b[2:0].
REQ-026 Opcodes 9-15 SHALL give, in the low WIDTH bits with the upper bits 0: AND, OR, XOR, NOT a, NAND, NOR, XNOR.
REQ-027 Opcode 2 SHALL stay in CALC with busy=1: result clears to 0 on entry, then increments every TICK_DIV cycles and wraps from all ones to 0; done SHALL not pulse.
REQ-028 In opcode 2, start=1 SHALL return the block to IDLE with result held; the new opcode is not executed on that edge.
REQ-029 In CALC (all other opcodes) and DONE, start SHALL be ignored.
REQ-030 Operand or opcode changes after the start edge SHALL not affect an in-flight operation.
REQ-031 result SHALL hold its value until the next update.

Reset
REQ-032 Asserting reset at any time, including mid-CALC, SHALL immediately force state IDLE, busy=0, done=0, error=0, result=0, iteration counter=0 and prescaler=0.
REQ-033 After reset deasserts, the block SHALL accept start on the first clk edge.

Verification
REQ-034 Multiply: opcode 5, a=0xFF, b=0xFF, start pulse -> done 9 cycles later, result=0xFE01, error=0.
REQ-035 Divide: opcode 6, a=200, b=7 -> result=0x041C (remainder 4, quotient 28).
REQ-036 Divide by zero: opcode 6, b=0 -> done after 2 cycles, result=0xFFFF, error=1.
REQ-037 Subtract: opcode 4, a=3, b=5 -> result=0xFFFE.
REQ-038 Count mode: opcode 2 with TICK_DIV=4 -> result steps 0,1,2 every 4 cycles; start -> IDLE, result held.
REQ-039 Reset mid-operation: reset asserted 3 cycles into a multiply -> outputs zero immediately; a new op after release completes correctly.
